// File: rtl/input_debouncer_if.sv
// ----------------------------------------------------------------------------
// input_debouncer_if
//   Groups the debouncer's control, raw-input and conditioned-output signals.
//   Optional macro: DEBOUNCE_EDGE_EN adds the per-channel rise/fall strobes.
//   Signals:
//     en        enable for the stability counters
//     raw_in    [NUM_CH] asynchronous pad inputs
//     clean_out [NUM_CH] debounced, registered levels
//     changed   one-cycle strobe when any clean_out bit flips
//     rise/fall [NUM_CH] one-cycle per-channel edge strobes (DEBOUNCE_EDGE_EN only)
//   Modports: master drives en/raw_in, slave (the debouncer) drives the outputs.
// ----------------------------------------------------------------------------
interface input_debouncer_if #(
  parameter int unsigned NUM_CH = 2
);
  logic              en;
  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] clean_out;
  logic              changed;
`ifdef DEBOUNCE_EDGE_EN
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
`endif

  modport master (
    output en,
    output raw_in,
    input  clean_out,
    input  changed
`ifdef DEBOUNCE_EDGE_EN
    ,
    input  rise,
    input  fall
`endif
  );

  modport slave (
    input  en,
    input  raw_in,
    output clean_out,
    output changed
`ifdef DEBOUNCE_EDGE_EN
    ,
    output rise,
    output fall
`endif
  );
endinterface

// File: rtl/input_debouncer.sv
// ----------------------------------------------------------------------------
// input_debouncer
//   Per channel: SYNC_STAGES-flop synchronizer followed by a stability counter.
//   clean_out follows the synchronized input only after DEBOUNCE_CYCLES
//   consecutive differing samples; any matching sample clears the count.
//   Optional macro: DEBOUNCE_EDGE_EN builds registered rise/fall strobes.
//   Ports:
//     clk    system clock, rising edge
//     rst    asynchronous, active-high reset
//     io_if  input_debouncer_if.slave (en, raw_in in; clean_out, changed,
//            and with DEBOUNCE_EDGE_EN rise/fall out)
//   Parameters: NUM_CH channels, SYNC_STAGES 2..4, DEBOUNCE_CYCLES >= 1.
// ----------------------------------------------------------------------------
module input_debouncer #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input_debouncer_if.slave   io_if
);

  localparam int unsigned CNT_W             = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;
  logic [NUM_CH-1:0][CNT_W-1:0]       r_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0]       w_cnt_nxt;
  logic [NUM_CH-1:0]                  r_clean;
  logic [NUM_CH-1:0]                  w_clean_nxt;
  logic [NUM_CH-1:0]                  w_sync;
  logic [NUM_CH-1:0]                  w_flip;
  logic                               r_changed;

  // Synchronizer chain; runs independently of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], io_if.raw_in};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Stability counter and output decision per channel
  always_comb begin
    w_cnt_nxt   = '0;
    w_clean_nxt = r_clean;
    if (io_if.en) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_sync[i] == r_clean[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == CNT_TERMINAL) begin
          // Enough consecutive differing samples: accept the new level
          w_clean_nxt[i] = w_sync[i];
          w_cnt_nxt[i]   = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_flip = w_clean_nxt ^ r_clean;

  // Counter, level and strobe registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_clean   <= '0;
      r_changed <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_clean   <= w_clean_nxt;
      r_changed <= |w_flip;
    end
  end

  assign io_if.clean_out = r_clean;
  assign io_if.changed   = r_changed;

`ifdef DEBOUNCE_EDGE_EN
  logic [NUM_CH-1:0] r_rise;
  logic [NUM_CH-1:0] r_fall;

  // Edge strobes, coincident with changed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_flip & w_clean_nxt;
      r_fall <= w_flip & ~w_clean_nxt;
    end
  end

  assign io_if.rise = r_rise;
  assign io_if.fall = r_fall;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

  localparam int NCH  = 2;
  localparam int SYNC = 2;
  localparam int DEB  = 16;

  typedef struct packed {
    logic [1:0] clean;
    logic       changed;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  input_debouncer_if #(.NUM_CH(NCH)) dif ();

  input_debouncer #(
    .NUM_CH(NCH),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .io_if(dif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Raw samples since reset (preloaded with zeros for the synchronizer), the
  // synchronized sample and enable seen at each edge, and the edge of each
  // channel's last accepted flip.
  exp_t       exp_q[$];
  logic [1:0] raw_q[$];
  logic [1:0] s_hist[$];
  bit         en_hist[$];
  int         last_flip[NCH];
  logic [1:0] m_clean;

  function automatic void model_reset();
    m_clean = 2'b00;
    raw_q.delete();
    for (int k = 0; k < SYNC; k++) raw_q.push_back(2'b00);
    s_hist.delete();
    en_hist.delete();
    for (int c = 0; c < NCH; c++) last_flip[c] = 0;
  endfunction

  // A channel flips at edge k when the last DEB synchronized samples were all
  // taken with en=1, all differ from the current level, and all follow the
  // previous flip of that channel.
  function automatic exp_t model_step(input bit en_v, input logic [1:0] raw_v);
    exp_t       e;
    logic [1:0] s;
    logic [1:0] nxt;
    int         k;
    bit         all_diff;
    s = raw_q[raw_q.size() - SYNC];
    raw_q.push_back(raw_v);
    s_hist.push_back(s);
    en_hist.push_back(en_v);
    k   = s_hist.size();
    nxt = m_clean;
    for (int c = 0; c < NCH; c++) begin
      if (k - last_flip[c] >= DEB) begin
        all_diff = 1'b1;
        for (int j = k - DEB; j < k; j++) begin
          if (!en_hist[j] || (s_hist[j][c] == m_clean[c])) all_diff = 1'b0;
        end
        if (all_diff) begin
          nxt[c]       = ~m_clean[c];
          last_flip[c] = k;
        end
      end
    end
    e.clean   = nxt;
    e.changed = (nxt != m_clean);
    e.rise    = nxt & ~m_clean;
    e.fall    = ~nxt & m_clean;
    m_clean   = nxt;
    return e;
  endfunction

  // One expected record per clock edge
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
      exp_q.push_back(exp_t'(0));
    end else begin
      exp_q.push_back(model_step(dif.en, dif.raw_in));
    end
  end

  // Asynchronous reset clears any not-yet-checked expectation immediately
  always @(posedge rst) begin
    model_reset();
    for (int k = 0; k < exp_q.size(); k++) exp_q[k] = exp_t'(0);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      bad = (dif.clean_out !== e.clean) || (dif.changed !== e.changed);
`ifdef DEBOUNCE_EDGE_EN
      bad = bad || (dif.rise !== e.rise) || (dif.fall !== e.fall);
`endif
      tests++;
      if (bad) begin
        fails++;
`ifdef DEBOUNCE_EDGE_EN
        $display("FAIL cycle_check t=%0t: got clean=%b changed=%b rise=%b fall=%b, want clean=%b changed=%b rise=%b fall=%b",
                 $time, dif.clean_out, dif.changed, dif.rise, dif.fall,
                 e.clean, e.changed, e.rise, e.fall);
`else
        $display("FAIL cycle_check t=%0t: got clean=%b changed=%b, want clean=%b changed=%b",
                 $time, dif.clean_out, dif.changed, e.clean, e.changed);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Edges from now until clean_out reaches target, compared to a fixed latency
  task automatic measure(input string name, input logic [1:0] target, input int want);
    int n;
    n = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #2;
      if (dif.clean_out == target) begin
        n = c;
        break;
      end
    end
    tests++;
    if (n != want) begin
      fails++;
      $display("FAIL %s: latency got %0d edges, want %0d (-1 = not reached)", name, n, want);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    dif.en     = 1'b1;
    dif.raw_in = 2'b11;

    // Reset held with inputs high, then full latency after release
    tick(3);
    rst = 1'b0;
    measure("reset_release", 2'b11, SYNC + DEB);
    dif.raw_in = 2'b00;
    tick(25);

    // Bouncing channel 0, then a final steady step
    for (int t = 0; t < 8; t++) begin
      dif.raw_in[0] = ~dif.raw_in[0];
      tick(5);
    end
    dif.raw_in[0] = 1'b1;
    measure("bounce_settle", 2'b01, SYNC + DEB);
    dif.raw_in[0] = 1'b0;
    tick(25);

    // Glitches one sample short of and exactly at the threshold
    dif.raw_in[1] = 1'b1;
    tick(DEB - 1);
    dif.raw_in[1] = 1'b0;
    tick(25);
    dif.raw_in[1] = 1'b1;
    tick(DEB);
    dif.raw_in[1] = 1'b0;
    tick(30);

    // Simultaneous step, then reset mid-count
    dif.raw_in = 2'b11;
    tick(25);
    dif.raw_in = 2'b00;
    tick(25);
    dif.raw_in = 2'b11;
    tick(10);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    measure("reset_mid_count", 2'b11, SYNC + DEB);
    dif.raw_in = 2'b00;
    tick(25);

    // Disabled counting, then a full count after enabling
    dif.en        = 1'b0;
    dif.raw_in[0] = 1'b1;
    tick(30);
    tests++;
    if (dif.clean_out != 2'b00) begin
      fails++;
      $display("FAIL en_low_hold: clean_out got %b, want 00", dif.clean_out);
    end
    dif.en = 1'b1;
    measure("en_restart", 2'b01, DEB);
    dif.raw_in = 2'b00;
    tick(25);

    // Randomized traffic with occasional disables and resets
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 13) == 0) dif.raw_in[c] = ~dif.raw_in[c];
      end
      if ($urandom_range(0, 149) == 0) dif.en = ~dif.en;
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
      tick(1);
    end
    dif.en = 1'b1;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
